calc_stream_ctrl: RTL and testbench

// - Parametrised memory-to-memory calculator controller, successor to the fixed 32/64-bit adder controller.
// - Streams operand pairs (A, B) from a read address window through an internal add/sub unit.
// - Packs LANES results per memory word and writes them to a write address window.
// - Has a start/busy/done handshake, runtime add/sub mode, a sticky overflow flag and range/truncation error reporting.

---
 rtl/calc_stream_ctrl.sv | 176 +++++++++++++++++
 tb/tb_calc_stream_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_stream_ctrl.sv
// Streaming memory-to-memory add/sub controller: reads operand pairs, packs LANES results per word.
// Optional macro CALC_STREAM_SAT_EN selects saturating arithmetic instead of wrap-around.
module calc_stream_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  localparam int WORD_W = DATA_W * LANES
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] rd_start_addr_i,
  input  logic [ADDR_W-1:0] rd_end_addr_i,
  input  logic [ADDR_W-1:0] wr_start_addr_i,
  input  logic [ADDR_W-1:0] wr_end_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ovf_o,
  output logic              r_en_o,
  output logic [ADDR_W-1:0] r_addr_o,
  input  logic [WORD_W-1:0] r_data_i,
  output logic              w_en_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [WORD_W-1:0] w_data_o,
  output logic [2:0]        state_o
);

  // Handshake: start_i is sampled only in IDLE; busy_o covers RD_A..WRITE, done_o pulses
  // one cycle in DONE with err_o valid alongside it; start_i outside IDLE has no effect.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_A  = 3'd1;
  localparam logic [2:0] S_RD_B  = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [2:0]        state;
  logic [ADDR_W-1:0] rd_ptr, rd_end, wr_ptr, wr_end;
  logic              mode;
  logic              rd_last;
  logic [DATA_W-1:0] op_a;
  logic [WORD_W-1:0] lane_buf;
  logic [LIDX_W-1:0] lane_idx;
  logic              err_q, ovf_q;

  logic              range_bad;
  logic              lane_full;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W:0]   add_ext, sub_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;

  // Odd operand count is detected from the LSBs: end-start+1 odd <=> end[0]==start[0].
  assign range_bad = (rd_end_addr_i < rd_start_addr_i) ||
                     (wr_end_addr_i < wr_start_addr_i) ||
                     (rd_end_addr_i[0] == rd_start_addr_i[0]);

  assign lane_full = (lane_idx == LIDX_W'(LANES - 1));
  assign op_b      = r_data_i[DATA_W-1:0];

  always_comb begin
    add_ext = {1'b0, op_a} + {1'b0, op_b};
    sub_ext = {1'b0, op_a} - {1'b0, op_b};
    alu_ovf = mode ? sub_ext[DATA_W] : add_ext[DATA_W];
`ifdef CALC_STREAM_SAT_EN
    if (alu_ovf) begin
      alu_res = mode ? '0 : '1;
    end else begin
      alu_res = mode ? sub_ext[DATA_W-1:0] : add_ext[DATA_W-1:0];
    end
`else
    alu_res = mode ? sub_ext[DATA_W-1:0] : add_ext[DATA_W-1:0];
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      rd_ptr   <= '0;
      rd_end   <= '0;
      wr_ptr   <= '0;
      wr_end   <= '0;
      mode     <= 1'b0;
      rd_last  <= 1'b0;
      op_a     <= '0;
      lane_buf <= '0;
      lane_idx <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            ovf_q    <= 1'b0;
            lane_buf <= '0;
            lane_idx <= '0;
            rd_last  <= 1'b0;
            if (range_bad) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end else begin
              err_q  <= 1'b0;
              mode   <= mode_i;
              rd_ptr <= rd_start_addr_i;
              rd_end <= rd_end_addr_i;
              wr_ptr <= wr_start_addr_i;
              wr_end <= wr_end_addr_i;
              state  <= S_RD_A;
            end
          end
        end
        S_RD_A: begin
          // An even count guarantees the B operand still lies within the window.
          rd_ptr <= rd_ptr + 1'b1;
          state  <= S_RD_B;
        end
        S_RD_B: begin
          op_a <= r_data_i[DATA_W-1:0];
          if (rd_ptr == rd_end) begin
            rd_last <= 1'b1;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
          end
          state <= S_CALC;
        end
        S_CALC: begin
          lane_buf[lane_idx*DATA_W +: DATA_W] <= alu_res;
          ovf_q    <= ovf_q | alu_ovf;
          lane_idx <= lane_idx + 1'b1;
          state    <= (lane_full || rd_last) ? S_WRITE : S_RD_A;
        end
        S_WRITE: begin
          lane_buf <= '0;
          lane_idx <= '0;
          if (rd_last) begin
            err_q <= 1'b0;
            state <= S_DONE;
          end else if (wr_ptr == wr_end) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
            state  <= S_RD_A;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign r_en_o   = (state == S_RD_A) || (state == S_RD_B);
  assign r_addr_o = r_en_o ? rd_ptr : '0;
  assign w_en_o   = (state == S_WRITE);
  assign w_addr_o = w_en_o ? wr_ptr : '0;
  assign w_data_o = w_en_o ? lane_buf : '0;
  assign busy_o   = (state == S_RD_A) || (state == S_RD_B) ||
                    (state == S_CALC) || (state == S_WRITE);
  assign done_o   = (state == S_DONE);
  assign err_o    = err_q;
  assign ovf_o    = ovf_q;
  assign state_o  = state;

  // Only lane 0 of each read word carries an operand.
  generate
    if (LANES > 1) begin : g_unused_rdata
      logic unused_rdata;
      assign unused_rdata = ^r_data_i[WORD_W-1:DATA_W];
    end
  endgenerate

endmodule

// File: tb/tb_calc_stream_ctrl.sv
// Scoreboard bench for calc_stream_ctrl: directed runs push expected writes/done status,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_calc_stream_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LANES  = 2;
  localparam int WORD_W = DATA_W * LANES;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_B = 3'd2;

`ifdef CALC_STREAM_SAT_EN
  localparam logic [31:0] ADD_OVF_RES = 32'hFFFF_FFFF;
  localparam logic [31:0] SUB_OVF_RES = 32'h0000_0000;
`else
  localparam logic [31:0] ADD_OVF_RES = 32'h0000_0001;
  localparam logic [31:0] SUB_OVF_RES = 32'hFFFF_FFFE;
`endif

  // clock / reset
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              start_i = 1'b0;
  logic              mode_i  = 1'b0;
  logic [ADDR_W-1:0] rd_start_addr_i = '0;
  logic [ADDR_W-1:0] rd_end_addr_i   = '0;
  logic [ADDR_W-1:0] wr_start_addr_i = '0;
  logic [ADDR_W-1:0] wr_end_addr_i   = '0;
  logic              busy_o, done_o, err_o, ovf_o;
  logic              r_en_o, w_en_o;
  logic [ADDR_W-1:0] r_addr_o, w_addr_o;
  logic [WORD_W-1:0] r_data_i, w_data_o;
  logic [2:0]        state_o;

  calc_stream_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
    .rd_start_addr_i(rd_start_addr_i), .rd_end_addr_i(rd_end_addr_i),
    .wr_start_addr_i(wr_start_addr_i), .wr_end_addr_i(wr_end_addr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .ovf_o(ovf_o),
    .r_en_o(r_en_o), .r_addr_o(r_addr_o), .r_data_i(r_data_i),
    .w_en_o(w_en_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
    .state_o(state_o)
  );

  // memory model with 1-cycle read latency
  logic [WORD_W-1:0] mem [256];
  always @(posedge clk_i) if (r_en_o) r_data_i <= mem[r_addr_o];

  int rd_cnt = 0;
  int wr_cnt = 0;
  always @(posedge clk_i) begin
    if (r_en_o) rd_cnt <= rd_cnt + 1;
    if (w_en_o) wr_cnt <= wr_cnt + 1;
  end

  // scoreboard
  logic [ADDR_W+WORD_W-1:0] exp_q[$];
  logic [1:0]               done_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic [ADDR_W+WORD_W-1:0] e;
    logic [1:0]               d;
    forever begin
      @(negedge clk_i);
      if (w_en_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h, required no write", w_addr_o, w_data_o);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", w_addr_o, e[ADDR_W+WORD_W-1:WORD_W]);
          check("write_data", w_data_o, e[WORD_W-1:0]);
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done_o=1, required 0");
        end else begin
          d = done_q.pop_front();
          check("done_err", err_o, d[1]);
          check("done_ovf", ovf_o, d[0]);
          check("busy_in_done", busy_o, 1'b0);
        end
      end
    end
  end

  // driver: one start pulse, then wait (bounded) for done_o
  task automatic run(input logic m, input logic [7:0] rs, input logic [7:0] re,
                     input logic [7:0] ws, input logic [7:0] we,
                     input int exp_rd, input int exp_wr, input int exp_lat, input bit extra);
    int cyc, rd0, wr0;
    @(posedge clk_i); #1;
    mode_i = m; rd_start_addr_i = rs; rd_end_addr_i = re;
    wr_start_addr_i = ws; wr_end_addr_i = we; start_i = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk_i); #1;
    start_i = 1'b0; mode_i = ~m;
    rd_start_addr_i = 8'h55; rd_end_addr_i = 8'h50; wr_start_addr_i = 8'h55; wr_end_addr_i = 8'h50;
    cyc = 1;
    check("busy_after_start", busy_o, exp_lat != 1);
    while (!done_o && cyc < 1000) begin
      if (extra && cyc == 2) begin
        rd_start_addr_i = 8'h40; rd_end_addr_i = 8'h41; start_i = 1'b1;
      end
      if (extra && cyc == 3) start_i = 1'b0;
      @(posedge clk_i); #1;
      cyc++;
    end
    check("done_seen", done_o, 1'b1);
    check("done_latency", cyc, exp_lat);
    @(posedge clk_i); #1;
    check("done_pulse", done_o, 1'b0);
    check("idle_after_done", state_o, S_IDLE);
    check("read_count", rd_cnt - rd0, exp_rd);
    check("write_count", wr_cnt - wr0, exp_wr);
    check("write_queue_empty", exp_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_r_en"}, r_en_o, 1'b0);
    check({tag, "_r_addr"}, r_addr_o, '0);
    check({tag, "_w_en"}, w_en_o, 1'b0);
    check({tag, "_w_data"}, w_data_o, '0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_err"}, err_o, 1'b0);
    check({tag, "_ovf"}, ovf_o, 1'b0);
    check({tag, "_state"}, state_o, S_IDLE);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cyc;
    for (int i = 0; i < 256; i++) mem[i] = {32'hDEAD_0000 | 32'(i), 32'h0};
    mem[0][31:0] = 32'd1;   mem[1][31:0] = 32'd2;
    mem[2][31:0] = 32'd3;   mem[3][31:0] = 32'd4;
    mem[4][31:0] = 32'd10;  mem[5][31:0] = 32'd20;
    mem[6][31:0] = 32'd100; mem[7][31:0] = 32'd200;
    mem[16][31:0] = 32'hFFFF_FFFF; mem[17][31:0] = 32'd2;
    mem[24][31:0] = 32'd5;  mem[25][31:0] = 32'd7;
    mem[254][31:0] = 32'd40; mem[255][31:0] = 32'd2;

    repeat (3) @(posedge clk_i);
    #1 check_all_zero("reset");
    @(negedge clk_i) rst_ni = 1'b1;

    // basic two-pair add into one word
    exp_q.push_back({8'd8, 64'h0000_0007_0000_0003}); done_q.push_back(2'b00);
    run(1'b0, 8'd0, 8'd3, 8'd8, 8'd8, 4, 1, 8, 1'b0);

    // odd operand count: no memory traffic
    done_q.push_back(2'b10);
    run(1'b0, 8'd0, 8'd2, 8'd8, 8'd8, 0, 0, 1, 1'b0);

    // add carry-out
    exp_q.push_back({8'd20, 32'h0, ADD_OVF_RES}); done_q.push_back(2'b01);
    run(1'b0, 8'd16, 8'd17, 8'd20, 8'd20, 2, 1, 5, 1'b0);

    // sub borrow
    exp_q.push_back({8'd21, 32'h0, SUB_OVF_RES}); done_q.push_back(2'b01);
    run(1'b1, 8'd24, 8'd25, 8'd21, 8'd21, 2, 1, 5, 1'b0);

    // three pairs, partial last word; a start pulse while busy must be ignored
    exp_q.push_back({8'd8, 64'h0000_0007_0000_0003});
    exp_q.push_back({8'd9, 64'h0000_0000_0000_001E}); done_q.push_back(2'b00);
    run(1'b0, 8'd0, 8'd5, 8'd8, 8'd9, 6, 2, 12, 1'b1);

    // truncation: four pairs into one word
    exp_q.push_back({8'd8, 64'h0000_0007_0000_0003}); done_q.push_back(2'b10);
    run(1'b0, 8'd0, 8'd7, 8'd8, 8'd8, 4, 1, 8, 1'b0);

    // reversed read window, reversed write window
    done_q.push_back(2'b10);
    run(1'b0, 8'd5, 8'd2, 8'd8, 8'd9, 0, 0, 1, 1'b0);
    done_q.push_back(2'b10);
    run(1'b0, 8'd0, 8'd3, 8'd9, 8'd8, 0, 0, 1, 1'b0);

    // top-of-memory windows terminate without wrapping
    exp_q.push_back({8'd255, 64'h0000_0000_0000_002A}); done_q.push_back(2'b00);
    run(1'b0, 8'd254, 8'd255, 8'd255, 8'd255, 2, 1, 5, 1'b0);

    // asynchronous reset while in RD_B
    @(posedge clk_i); #1;
    mode_i = 1'b0; rd_start_addr_i = 8'd0; rd_end_addr_i = 8'd3;
    wr_start_addr_i = 8'd8; wr_end_addr_i = 8'd8; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cyc = 0;
    while (state_o != S_RD_B && cyc < 20) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("reach_rd_b", state_o, S_RD_B);
    #2 rst_ni = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk_i);
    check_all_zero("held_reset");
    rst_ni = 1'b1;

    exp_q.push_back({8'd8, 64'h0000_0007_0000_0003}); done_q.push_back(2'b00);
    run(1'b0, 8'd0, 8'd3, 8'd8, 8'd8, 4, 1, 8, 1'b0);

    repeat (2) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
